disp_arbiter: RTL and testbench
===============================

Name: disp_arbiter

Overview:
- Shares the four-digit seven-segment display between up to NREQ requesters, e.g. CPU MMIO, switch echo and debug probes.
- Arbitrates round-robin with a minimum on-screen hold time per owner.
- Decodes the winning requester's 16-bit hex value into segment patterns.
- Drives the 32-bit DispReg input of the seven-segment driver. Patterns are active-high; the driver inverts them.

Parameters:
- NREQ, 4: number of requesters. Legal range 1..4.
- HOLD_CYCLES, 100000000: minimum fpgaClk cycles an owner keeps the display (1 s at 100 MHz). Must be >= 2.
- CNTW, 27: width of the hold counter. Must satisfy 2^CNTW > HOLD_CYCLES.

Ports:
- fpgaClk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- req_valid, input, NREQ: requester i has a value to display.
- req_data, input, 16*NREQ: requester i value in bits [16i+15:16i], as 4 hex nibbles; nibble 0 maps to the rightmost digit.
- req_ready, output, NREQ: one-hot; high in the cycle requester i's data is accepted.
- DispReg, output, 32: byte k is the pattern for digit k, bit order {dp,g,f,e,d,c,b,a}.
- owner, output, 2: index of the current display owner.
- owner_valid, output, 1: high once any request has been granted since reset.

Behaviour:
- Reset (async): DispReg=0 (all blank), owner=0, owner_valid=0, req_ready=0, hold counter=0, state=IDLE, round-robin pointer=0.
- States: IDLE and SHOW.
- IDLE:
  - Display blank.
  - On any req_valid, grant the first valid requester scanning from pointer upward, modulo NREQ.
  - Drive req_ready[grant]=1 combinationally in the same cycle.
  - Next edge: latch data, owner=grant, owner_valid=1, pointer=grant+1 mod NREQ, counter=HOLD_CYCLES-1, state=SHOW.
- SHOW:
  - Counter decrements by 1 per cycle and saturates at 0.
  - While counter != 0: only the owner is served. If req_valid[owner]=1 then req_ready[owner]=1 and the data is re-latched. The counter does not reload. Other requesters wait with ready=0.
  - When counter == 0, scan all requesters starting at pointer. The owner is included but is last in order because pointer=owner+1.
  - If the scan finds a winner: grant and reload exactly as from IDLE. A winner equal to the owner is a re-grant with counter reload.
  - If no request is valid: hold the last displayed value indefinitely and grant on the first later request with zero added latency.
  - Counter==0 with an owner update in the same cycle: arbitration wins. The owner is accepted only if it is the scan winner.
- Latency: accepted data appears on DispReg on the edge after req_ready is high. DispReg and owner are registered.
- Decode, per nibble:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07.
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- Owner indicator: the dp bit (bit 7) of digit[owner] is set; all other dp bits are 0.
- Requesters with index >= NREQ do not exist; owner never exceeds NREQ-1.
- Reset mid-SHOW: immediate return to the reset state; in-flight data is discarded.

Optional Feature:
- Macro: DISP_LEADING_ZERO_BLANK_EN.
- Defined: digits 3..1 whose nibble is 0, and all higher digits also 0, show segment bits 0x00. Digit 0 is always shown. The owner dp bit is still applied to blanked digits. Example: 0x0050 displays as blank, blank, 5, 0.
- Undefined: all four digits are always decoded; 0x0050 displays 0, 0, 5, 0.

Test Plan (HOLD_CYCLES=8, NREQ=4):
- Reset, then req_valid=0001 with req_data[15:0]=0x1234: req_ready=0001 for 1 cycle; next cycle DispReg=0x065B4F66 | dp in digit0 = 0x065B4FE6, owner=0, owner_valid=1.
- Owner 0 holds; req0 updates to 0xABCD 3 cycles after grant while req2 is valid: req0 accepted, DispReg digits=77,7C,39,5E (dp digit0); req2 gets ready exactly at counter==0, 8 cycles after the original grant; owner=2.
- req1, req2, req3 all continuously valid: grants rotate 1→2→3→1, each held 8 cycles; no requester starved.
- All requests drop after grant: display holds last value; a req3 raised 50 cycles later gets ready in the same cycle.
- Counter==0 while owner 1 updates and req3 is valid: req_ready=1000, owner's update is not latched.
- Assert reset mid-SHOW: DispReg=0, owner_valid=0 immediately. With DISP_LEADING_ZERO_BLANK_EN, value 0x0007 displays bytes 00,00,00,87 (digit0 = 07 | dp).

Source files
------------

// File: rtl/disp_arbiter_if.sv
// -----------------------------------------------------------------------------
// disp_arbiter_if
// Requester-side handshake bundle for the seven-segment display arbiter.
//   req_valid [NREQ-1:0]    : requester i has a value to show
//   req_data  [16*NREQ-1:0] : requester i value in bits [16i+15:16i]
//   req_ready [NREQ-1:0]    : one-hot, high in the cycle requester i is accepted
// Modports: master = requesters (drive valid/data), slave = arbiter.
// -----------------------------------------------------------------------------
interface disp_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req_valid;
    logic [16*NREQ-1:0] req_data;
    logic [NREQ-1:0]    req_ready;

    modport master (output req_valid, output req_data, input req_ready);
    modport slave  (input req_valid, input req_data, output req_ready);
endinterface

// File: rtl/disp_arbiter.sv
// -----------------------------------------------------------------------------
// disp_arbiter
// Round-robin owner selection for the four-digit seven-segment display with a
// minimum hold time per owner, plus hex-to-segment decode of the owner value.
//   fpgaClk     : system clock
//   reset       : asynchronous, active-high reset
//   req         : disp_arbiter_if.slave (req_valid, req_data, req_ready)
//   DispReg     : 32-bit active-high patterns, byte k = digit k {dp,g..a}
//   owner       : index of the current display owner
//   owner_valid : high once any request has been granted since reset
// Optional build macro: DISP_LEADING_ZERO_BLANK_EN blanks leading zero digits
// (digits 3..1); digit 0 is always shown and the owner dp bit is kept.
// -----------------------------------------------------------------------------
module disp_arbiter #(
    parameter int NREQ        = 4,
    parameter int HOLD_CYCLES = 100000000,
    parameter int CNTW        = 27
) (
    input  logic               fpgaClk,
    input  logic               reset,
    disp_arbiter_if.slave      req,
    output logic [31:0]        DispReg,
    output logic [1:0]         owner,
    output logic               owner_valid
);

    typedef enum logic {IDLE = 1'b0, SHOW = 1'b1} state_t;

    localparam logic [2:0]      NREQ_W   = 3'(NREQ);
    localparam logic [1:0]      LAST_REQ = 2'(NREQ - 1);
    localparam logic [CNTW-1:0] HOLD_LD  = CNTW'(HOLD_CYCLES - 1);

    state_t          state_r;
    logic [CNTW-1:0] cnt_r;
    logic [1:0]      ptr_r;

    logic            found_s;
    logic [1:0]      win_s;
    logic            arb_s;
    logic            grant_s;
    logic            upd_s;
    logic [NREQ-1:0] ready_s;
    logic [15:0]     win_data_s;
    logic [15:0]     own_data_s;

    // Hex nibble to active-high segments {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            4'hF:    s = 7'h71;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Full 32-bit display word: four decoded digits, dp marks the owner digit.
    function automatic logic [31:0] disp_word(input logic [15:0] val,
                                              input logic [1:0]  own);
        logic [31:0] w;
        logic [6:0]  s;
`ifdef DISP_LEADING_ZERO_BLANK_EN
        logic        lz;
        lz = 1'b1;
`endif
        w = 32'h0000_0000;
        for (int k = 3; k >= 0; k--) begin
            s = seg7(val[4*k +: 4]);
`ifdef DISP_LEADING_ZERO_BLANK_EN
            // lz stays set only while every digit from 3 down to k is zero.
            lz = lz & (val[4*k +: 4] == 4'h0);
            if (lz && (k != 0)) begin
                s = 7'h00;
            end else begin
                s = s;
            end
`endif
            w[8*k +: 8] = {(2'(k) == own), s};
        end
        return w;
    endfunction

    // Round-robin scan: first valid requester at or above ptr_r, modulo NREQ.
    always_comb begin
        found_s = 1'b0;
        win_s   = 2'd0;
        for (int k = 0; k < NREQ; k++) begin
            logic [2:0] sum;
            logic [1:0] idx;
            sum = {1'b0, ptr_r} + 3'(k);
            idx = (sum >= NREQ_W) ? 2'(sum - NREQ_W) : sum[1:0];
            if (!found_s && req.req_valid[idx]) begin
                found_s = 1'b1;
                win_s   = idx;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Handshake decode: arbitration in IDLE or on hold expiry, else owner-only.
    always_comb begin
        ready_s = {NREQ{1'b0}};
        arb_s   = (state_r == IDLE) || (cnt_r == {CNTW{1'b0}});
        grant_s = arb_s && found_s;
        upd_s   = !arb_s && req.req_valid[owner];
        if (reset) begin
            ready_s = {NREQ{1'b0}};
        end else if (grant_s) begin
            ready_s[win_s] = 1'b1;
        end else if (upd_s) begin
            ready_s[owner] = 1'b1;
        end else begin
            ready_s = {NREQ{1'b0}};
        end
    end

    assign req.req_ready = ready_s;
    assign win_data_s    = req.req_data[{win_s, 4'b0000} +: 16];
    assign own_data_s    = req.req_data[{owner, 4'b0000} +: 16];

    // Owner FSM: grant/reload, hold countdown, and registered display outputs.
    always_ff @(posedge fpgaClk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= {CNTW{1'b0}};
            ptr_r       <= 2'd0;
            owner       <= 2'd0;
            owner_valid <= 1'b0;
            DispReg     <= 32'h0000_0000;
        end else begin
            if (grant_s) begin
                state_r     <= SHOW;
                cnt_r       <= HOLD_LD;
                ptr_r       <= (win_s == LAST_REQ) ? 2'd0 : win_s + 2'd1;
                owner       <= win_s;
                owner_valid <= 1'b1;
                DispReg     <= disp_word(win_data_s, win_s);
            end else begin
                case (state_r)
                    IDLE: begin
                        DispReg <= 32'h0000_0000;
                    end
                    SHOW: begin
                        // Counter saturates at zero; with no request the last
                        // value stays on screen until the next grant.
                        if (cnt_r != {CNTW{1'b0}}) begin
                            cnt_r <= cnt_r - CNTW'(1);
                        end else begin
                            cnt_r <= cnt_r;
                        end
                        if (upd_s) begin
                            DispReg <= disp_word(own_data_s, owner);
                        end else begin
                            DispReg <= DispReg;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_disp_arbiter.sv
// -----------------------------------------------------------------------------
// tb_disp_arbiter
// Scoreboard bench for disp_arbiter (NREQ=4, HOLD_CYCLES=8). A cycle model of
// the arbiter predicts req_ready each cycle; on every predicted acceptance the
// expected display word and owner are queued and compared one cycle later.
// -----------------------------------------------------------------------------
module tb_disp_arbiter;

    localparam int HOLD = 8;

    typedef struct packed {
        logic [31:0] disp;
        logic [1:0]  own;
    } exp_t;

    logic        fpgaClk;
    logic        reset;
    logic [31:0] DispReg;
    logic [1:0]  owner;
    logic        owner_valid;

    disp_arbiter_if #(.NREQ(4)) req_if ();

    disp_arbiter #(.NREQ(4), .HOLD_CYCLES(HOLD), .CNTW(4)) dut (
        .fpgaClk     (fpgaClk),
        .reset       (reset),
        .req         (req_if),
        .DispReg     (DispReg),
        .owner       (owner),
        .owner_valid (owner_valid)
    );

    initial fpgaClk = 1'b0;
    always #5 fpgaClk = ~fpgaClk;

    logic [7:0] seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    int   vectors;
    int   miscompares;
    exp_t sb [$];
    exp_t last_exp;
    int   m_state, m_cnt, m_owner, m_ptr, m_ov;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [15:0] val, input int own);
        logic [31:0] w;
        logic [7:0]  b;
        w = 32'h0;
        for (int k = 0; k < 4; k++) begin
            b = seg_tab[val[4*k +: 4]];
`ifdef DISP_LEADING_ZERO_BLANK_EN
            if (k > 0 && (val >> (4*k)) == 16'h0) b = 8'h00;
`endif
            if (k == own) b = b | 8'h80;
            w[8*k +: 8] = b;
        end
        return w;
    endfunction

    task automatic model_clear();
        m_state = 0; m_cnt = 0; m_owner = 0; m_ptr = 0; m_ov = 0;
        sb.delete();
        last_exp = '0;
    endtask

    // Reset (also used mid-SHOW): outputs must clear without waiting for a clock.
    task automatic do_reset();
        reset = 1'b1;
        req_if.req_valid = 4'b1111;
        req_if.req_data  = 64'h1111_2222_3333_4444;
        #1;
        check("rst_disp", DispReg, 32'h0);
        check("rst_owner", {30'h0, owner}, 32'h0);
        check("rst_ovalid", {31'h0, owner_valid}, 32'h0);
        check("rst_ready", {28'h0, req_if.req_ready}, 32'h0);
        @(posedge fpgaClk);
        #2;
        reset = 1'b0;
        req_if.req_valid = 4'b0000;
        model_clear();
    endtask

    // One clock: compare outputs from the previous edge, predict ready, advance.
    task automatic cycle(input logic [3:0] v, input logic [63:0] d);
        logic [3:0]  er;
        logic [15:0] val;
        int          w;
        req_if.req_valid = v;
        req_if.req_data  = d;
        #2;
        if (sb.size() > 0) last_exp = sb.pop_front();
        check("disp", DispReg, last_exp.disp);
        check("owner", {30'h0, owner}, {30'h0, last_exp.own});
        check("ovalid", {31'h0, owner_valid}, m_ov);
        er = 4'b0000;
        w  = -1;
        if (m_state == 0 || m_cnt == 0) begin
            for (int k = 0; k < 4; k++) begin
                if (w < 0 && v[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
            end
            if (w >= 0) er[w] = 1'b1;
        end else if (v[m_owner]) begin
            er[m_owner] = 1'b1;
        end
        check("ready", {28'h0, req_if.req_ready}, {28'h0, er});
        if (w >= 0) begin
            val = 16'(d >> (16*w));
            sb.push_back('{exp_word(val, w), 2'(w)});
        end else if (er != 4'b0000) begin
            val = 16'(d >> (16*m_owner));
            sb.push_back('{exp_word(val, m_owner), 2'(m_owner)});
        end
        @(posedge fpgaClk);
        if (w >= 0) begin
            m_owner = w; m_ptr = (w + 1) % 4; m_cnt = HOLD - 1; m_state = 1; m_ov = 1;
        end else if (m_state == 1 && m_cnt > 0) begin
            m_cnt--;
        end
        #2;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        req_if.req_valid = 4'b0000;
        req_if.req_data  = 64'h0;
        model_clear();
        do_reset();
        cycle(4'b0000, 64'h0);

        // First grant of requester 0 with 0x1234.
        cycle(4'b0001, 64'h0000_0000_0000_1234);
        check("t1_disp", DispReg, 32'h065B4FE6);
        check("t1_owner", {30'h0, owner}, 32'h0);
        check("t1_ovalid", {31'h0, owner_valid}, 32'h1);

        // Owner update during hold while req2 waits for expiry.
        cycle(4'b0100, 64'h0000_5555_0000_1234);
        cycle(4'b0100, 64'h0000_5555_0000_1234);
        cycle(4'b0101, 64'h0000_5555_0000_ABCD);
        check("t2_upd", DispReg, 32'h777C39DE);
        for (int i = 0; i < 6; i++) cycle(4'b0100, 64'h0000_5555_0000_ABCD);
        check("t2_owner", {30'h0, owner}, 32'h2);

        // Continuous contention from 1, 2, 3: rotation checked by the model.
        for (int i = 0; i < 40; i++) cycle(4'b1110, 64'h3333_2222_1111_0000);

        // All requests drop; a late req3 is served with zero latency.
        for (int i = 0; i < 50; i++) cycle(4'b0000, 64'h0);
        cycle(4'b1000, 64'h9876_0000_0000_0000);

        // Owner 1 updates exactly when its hold expires while req3 is valid.
        for (int i = 0; i < 10; i++) cycle(4'b0010, 64'h0000_0000_1111_0000);
        for (int i = 0; i < 4; i++)  cycle(4'b0010, 64'h0000_0000_4444_0000);
        for (int i = 0; i < 6; i++)  cycle(4'b1010, 64'h3333_0000_2222_0000);
        check("t5_owner", {30'h0, owner}, 32'h3);

        // Reset in the middle of SHOW.
        cycle(4'b1000, 64'h3333_0000_0000_0000);
        do_reset();

        // Leading-zero handling of digits 3..1.
        cycle(4'b0001, 64'h0000_0000_0000_0007);
`ifdef DISP_LEADING_ZERO_BLANK_EN
        check("lz_0007", DispReg, 32'h00000087);
`else
        check("lz_0007", DispReg, 32'h3F3F3F87);
`endif
        cycle(4'b0001, 64'h0000_0000_0000_0050);
`ifdef DISP_LEADING_ZERO_BLANK_EN
        check("lz_0050", DispReg, 32'h00006DBF);
`else
        check("lz_0050", DispReg, 32'h3F3F6DBF);
`endif
        cycle(4'b0000, 64'h0);
        cycle(4'b0000, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
